// File: rtl/booth_pkg.sv
// ============================================================================
//  Module  : booth_pkg
//  Brief   : Shared state encoding and Booth decode constants for booth_seq_mult
//  Revision: 1.0
// ============================================================================
`default_nettype none

package booth_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // {Q[0], Q_1} pairs that trigger an add or a subtract of M
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/booth_step.sv
// ============================================================================
//  Module  : booth_step
//  Brief   : One combinational radix-2 Booth iteration (add/sub then shift)
//  Revision: 1.0
// ============================================================================
`default_nettype none

module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             q1_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q1_o
);

    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;

    // One guard bit on A keeps the subtraction of the most-negative M exact
    assign m_ext = {m_i[WIDTH-1], m_i};

    always_comb begin
        sum = a_i;
        case ({q_i[0], q1_i})
            BOOTH_ADD: sum = a_i + m_ext;
            BOOTH_SUB: sum = a_i - m_ext;
            default:   sum = a_i;
        endcase
    end

    assign a_o  = {sum[WIDTH], sum[WIDTH:1]};
    assign q_o  = {sum[0], q_i[WIDTH-1:1]};
    assign q1_o = q_i[0];

endmodule

`default_nettype wire

// File: rtl/booth_seq_mult.sv
// ============================================================================
//  Module  : booth_seq_mult
//  Brief   : Sequential radix-2 Booth signed multiplier, WIDTH iterations/op
//  Revision: 1.0
// ============================================================================
`default_nettype none

module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e               state_q, state_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 q1_q, q1_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [WIDTH:0]       step_a;
    logic [WIDTH-1:0]     step_q;
    logic                 step_q1;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a_i  (a_q),
        .q_i  (q_q),
        .q1_i (q1_q),
        .m_i  (m_q),
        .a_o  (step_a),
        .q_o  (step_q),
        .q1_o (step_q1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            m_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        q1_d    = q1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    a_d     = '0;
                    q1_d    = 1'b0;
                    cnt_d   = CNT_W'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = ITER;
                end
            end
            ITER: begin
                a_d   = step_a;
                q_d   = step_q;
                q1_d  = step_q1;
                cnt_d = cnt_q - CNT_W'(1);
                // Final iteration: the shifted {A,Q} already holds the product
                if (cnt_q == CNT_W'(1)) begin
                    prod_d  = {step_a[WIDTH-1:0], step_q};
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign product = prod_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

`default_nettype wire
